// File: rtl/data_memory_responder_if.sv
`default_nettype none
// ============================================================================
// Interface : data_memory_responder_if
// Purpose   : request/response bundle between the core and the data memory.
// Revision  : 1.0
// ============================================================================
interface data_memory_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_address;
   logic [2:0]  req_funct3;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_error;

   modport master (
      output req_valid, req_write, req_address, req_funct3, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_error
   );

   modport slave (
      input  req_valid, req_write, req_address, req_funct3, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_error
   );
endinterface
`default_nettype wire

// File: rtl/data_memory_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_responder
// Purpose  : single-outstanding data memory with wait states, byte-lane
//            placement/extraction and access checking.
// Revision : 1.0
// ============================================================================
module data_memory_responder #(
   parameter int unsigned DEPTH_WORDS  = 4096,
   parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
   parameter int unsigned WAIT_CYCLES  = 1
) (
   input  wire logic              clk,
   input  wire logic              reset_n,
   data_memory_responder_if.slave bus
);
   localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
   localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) << 2;
   localparam logic [3:0]  WAIT_LOAD  = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT    = 2'd1,
      S_RESPOND = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        write_q;
   logic [31:0] addr_q;
   logic [2:0]  funct3_q;
   logic [31:0] wdata_q;
   logic        valid_q;
   logic [31:0] rdata_q;
   logic        error_q;

   logic        w_idle;
   logic        w_accept;
   logic        w_exec;
   logic        w_commit;
   logic        w_write;
   logic [31:0] w_addr;
   logic [2:0]  w_funct3;
   logic [31:0] w_wdata;
   logic [32:0] w_diff;
   logic [1:0]  w_lane;
   logic [IDX_W-1:0] w_idx;
   logic        w_range_err;
   logic        w_f3_err;
   logic        w_align_err;
   logic        w_err;
   logic [3:0]  w_be;
   logic [31:0] w_wbytes;
   logic [31:0] w_rword;
   logic [31:0] w_shifted;
   logic [31:0] w_load;
   logic        w_unused_shift;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      w_idle  = 1'b0;
      case (state_q)
         S_IDLE: begin
            w_idle = 1'b1;
            if (bus.req_valid) begin
               cnt_d   = WAIT_LOAD;
               state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESPOND;
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) state_d = S_RESPOND;
            else               cnt_d   = cnt_q - 4'd1;
         end
         S_RESPOND: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   assign bus.req_ready = reset_n & w_idle;
   assign w_accept      = bus.req_valid & bus.req_ready;
   // Execution happens on the edge entering RESPOND; always a single edge.
   assign w_exec        = reset_n & (state_d == S_RESPOND);

   // With no wait states the request executes on its own acceptance edge,
   // before the request registers hold it, so decode straight from the bus.
   always_comb begin
      if (state_q == S_IDLE) begin
         w_write  = bus.req_write;
         w_addr   = bus.req_address;
         w_funct3 = bus.req_funct3;
         w_wdata  = bus.req_wdata;
      end else begin
         w_write  = write_q;
         w_addr   = addr_q;
         w_funct3 = funct3_q;
         w_wdata  = wdata_q;
      end
   end

   assign w_diff      = {1'b0, w_addr} - {1'b0, BASE_ADDRESS};
   assign w_lane      = w_diff[1:0];
   assign w_idx       = w_diff[IDX_W+1:2];
   assign w_range_err = w_diff[32] | ({1'b0, w_diff[31:0]} >= SPAN_BYTES);

   always_comb begin
      w_f3_err    = 1'b0;
      w_align_err = 1'b0;
      w_be        = 4'b0000;
      w_wbytes    = w_wdata;
      case (w_funct3)
         3'b000: begin
            w_be     = 4'b0001 << w_lane;
            w_wbytes = {4{w_wdata[7:0]}};
         end
         3'b100: w_f3_err = w_write;
         3'b001: begin
            w_align_err = w_lane[0];
            w_be        = 4'b0011 << w_lane;
            w_wbytes    = {2{w_wdata[15:0]}};
         end
         3'b101: begin
            w_f3_err    = w_write;
            w_align_err = w_lane[0];
         end
         3'b010: begin
            w_align_err = (w_lane != 2'b00);
            w_be        = 4'b1111;
         end
         default: w_f3_err = 1'b1;
      endcase
   end

   assign w_err    = w_range_err | w_f3_err | w_align_err;
   assign w_commit = w_exec & w_write & ~w_err;

   for (genvar g = 0; g < 4; g++) begin : g_lane
      logic [7:0] lane_mem_q [DEPTH_WORDS];

      always_ff @(posedge clk) begin
         if (w_commit && w_be[g]) lane_mem_q[w_idx] <= w_wbytes[8*g +: 8];
      end

      assign w_rword[8*g +: 8] = lane_mem_q[w_idx];
   end

   assign w_shifted      = w_rword >> {w_lane, 3'b000};
   assign w_unused_shift = ^w_shifted[31:16];

   always_comb begin
      case (w_funct3)
         3'b000, 3'b100: w_load = {24'd0, w_shifted[7:0]};
         3'b001, 3'b101: w_load = {16'd0, w_shifted[15:0]};
         default:        w_load = w_rword;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= 4'd0;
         write_q  <= 1'b0;
         addr_q   <= 32'd0;
         funct3_q <= 3'd0;
         wdata_q  <= 32'd0;
         valid_q  <= 1'b0;
         rdata_q  <= 32'd0;
         error_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         valid_q <= w_exec;
         if (w_accept) begin
            write_q  <= bus.req_write;
            addr_q   <= bus.req_address;
            funct3_q <= bus.req_funct3;
            wdata_q  <= bus.req_wdata;
         end
         if (w_exec) begin
            rdata_q <= (w_err || w_write) ? 32'd0 : w_load;
            error_q <= w_err;
         end
      end
   end

   assign bus.resp_valid = valid_q;
   assign bus.resp_rdata = rdata_q;
   assign bus.resp_error = error_q;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory_responder
// Purpose  : three responders (different wait states / bases) driven with
//            directed and random requests, scored against a byte-array model.
// Revision : 1.0
// ============================================================================
module tb_data_memory_responder;
   localparam int N     = 3;
   localparam int DEPTH = 4096;
   localparam int unsigned WAIT_TAB [N] = '{1, 0, 3};
   localparam logic [31:0] BASE_TAB [N] = '{32'h0000_0000, 32'h0000_0000, 32'h1000_0000};

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   int          cyc = 0;
   int          checks = 0;
   int          passes = 0;

   logic        rst_n [N];
   logic        v     [N];
   logic        wr    [N];
   logic [31:0] ad    [N];
   logic [2:0]  f3    [N];
   logic [31:0] wd    [N];
   logic        rdy   [N];
   logic        rv    [N];
   logic [31:0] rd    [N];
   logic        re    [N];

   exp_t        exp_q [N][$];
   logic [7:0]  mb    [N][4*DEPTH];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (ok) passes++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // Reference: byte-addressed memory and the access rules in plain arithmetic.
   function automatic void model(input int i, input bit w, input logic [31:0] a, input logic [2:0] f,
                                 input logic [31:0] d, input bit commit,
                                 output logic err, output logic [31:0] rdat);
      longint off;
      int     sz;
      bit     legal;
      off = longint'({32'd0, a}) - longint'({32'd0, BASE_TAB[i]});
      case (f)
         3'b000: begin sz = 1; legal = 1'b1; end
         3'b100: begin sz = 1; legal = !w;   end
         3'b001: begin sz = 2; legal = 1'b1; end
         3'b101: begin sz = 2; legal = !w;   end
         3'b010: begin sz = 4; legal = 1'b1; end
         default: begin sz = 1; legal = 1'b0; end
      endcase
      err  = !legal || off < 0 || off >= 4 * DEPTH || (off % sz) != 0;
      rdat = 32'd0;
      if (!err) begin
         for (int k = 0; k < sz; k++) begin
            if (w) begin
               if (commit) mb[i][int'(off) + k] = d[8*k +: 8];
            end else begin
               rdat[8*k +: 8] = mb[i][int'(off) + k];
            end
         end
      end
   endfunction

   for (genvar g = 0; g < N; g++) begin : g_dut
      data_memory_responder_if bus_if ();

      assign bus_if.req_valid   = v[g];
      assign bus_if.req_write   = wr[g];
      assign bus_if.req_address = ad[g];
      assign bus_if.req_funct3  = f3[g];
      assign bus_if.req_wdata   = wd[g];
      assign rdy[g] = bus_if.req_ready;
      assign rv[g]  = bus_if.resp_valid;
      assign rd[g]  = bus_if.resp_rdata;
      assign re[g]  = bus_if.resp_error;

      data_memory_responder #(
         .DEPTH_WORDS  (DEPTH),
         .BASE_ADDRESS (BASE_TAB[g]),
         .WAIT_CYCLES  (WAIT_TAB[g])
      ) dut (
         .clk     (clk),
         .reset_n (rst_n[g]),
         .bus     (bus_if)
      );

      // Monitor: ready must be high exactly when nothing is outstanding.
      always @(negedge clk) begin
         exp_t e;
         bit   exp_rdy;
         if (!rst_n[g]) begin
            exp_q[g].delete();
            chk(rdy[g] === 1'b0, $sformatf("dut%0d ready_in_reset", g), 32'(rdy[g]), 32'd0);
            chk(rv[g] === 1'b0, $sformatf("dut%0d valid_in_reset", g), 32'(rv[g]), 32'd0);
         end else begin
            exp_rdy = (exp_q[g].size() == 0);
            chk(rdy[g] === exp_rdy, $sformatf("dut%0d req_ready", g), 32'(rdy[g]), 32'(exp_rdy));
            if (rv[g] === 1'b1) begin
               if (exp_q[g].size() == 0) begin
                  chk(1'b0, $sformatf("dut%0d unexpected_resp_valid", g), 32'd1, 32'd0);
               end else begin
                  e = exp_q[g].pop_front();
                  chk(rd[g] === e.rdata, $sformatf("dut%0d resp_rdata", g), rd[g], e.rdata);
                  chk(re[g] === e.err, $sformatf("dut%0d resp_error", g), 32'(re[g]), 32'(e.err));
                  chk(cyc == e.cyc, $sformatf("dut%0d resp_latency_cycle", g), 32'(cyc), 32'(e.cyc));
               end
            end
         end
      end
   end

   // Leaves req_valid high so a following call forms a back-to-back stream.
   task automatic send(input int i, input bit w, input logic [31:0] a, input logic [2:0] f,
                       input logic [31:0] d, input bit commit);
      exp_t        e;
      int          n;
      logic        err;
      logic [31:0] rdat;
      wr[i] = w; ad[i] = a; f3[i] = f; wd[i] = d; v[i] = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (rdy[i] !== 1'b1 && n < 64);
      if (rdy[i] !== 1'b1) begin
         chk(1'b0, $sformatf("dut%0d accept_timeout", i), 32'(rdy[i]), 32'd1);
         v[i] = 1'b0;
         return;
      end
      model(i, w, a, f, d, commit, err, rdat);
      e.err   = err;
      e.rdata = rdat;
      e.cyc   = cyc + 1 + int'(WAIT_TAB[i]);
      @(posedge clk);
      exp_q[i].push_back(e);
      #1;
   endtask

   task automatic rand_run(input int i, input int cnt);
      logic [31:0] b;
      logic [31:0] a;
      int          r;
      b = BASE_TAB[i];
      for (int k = 0; k < 16; k++) send(i, 1'b1, b + 32'(4 * k), 3'b010, $urandom, 1'b1);
      for (int k = 0; k < cnt; k++) begin
         r = $urandom_range(0, 9);
         if (r == 0)      a = b + 32'h4000 + 32'($urandom_range(0, 255));
         else if (r == 1) a = b - 32'($urandom_range(1, 64));
         else             a = b + 32'($urandom_range(0, 63));
         send(i, 1'($urandom_range(0, 1)), a, 3'($urandom_range(0, 7)), $urandom, 1'b1);
         if ($urandom_range(0, 3) == 0) begin
            v[i] = 1'b0;
            @(posedge clk);
            #1;
         end
      end
      v[i] = 1'b0;
   endtask

   task automatic directed0();
      send(0, 1'b1, 32'h10, 3'b010, 32'hDEAD_BEEF, 1'b1);
      send(0, 1'b0, 32'h10, 3'b010, 32'h0, 1'b1);
      send(0, 1'b1, 32'h20, 3'b010, 32'h1122_3344, 1'b1);
      send(0, 1'b1, 32'h22, 3'b000, 32'h0000_00AA, 1'b1);
      send(0, 1'b0, 32'h20, 3'b010, 32'h0, 1'b1);
      send(0, 1'b0, 32'h22, 3'b000, 32'h0, 1'b1);
      send(0, 1'b0, 32'h22, 3'b101, 32'h0, 1'b1);
      send(0, 1'b0, 32'h21, 3'b010, 32'h0, 1'b1);
      send(0, 1'b1, 32'h23, 3'b001, 32'h0000_FFFF, 1'b1);
      send(0, 1'b0, 32'h20, 3'b010, 32'h0, 1'b1);
      send(0, 1'b0, 32'h4000, 3'b010, 32'h0, 1'b1);
      send(0, 1'b0, 32'h0, 3'b011, 32'h0, 1'b1);
      send(0, 1'b1, 32'h20, 3'b100, 32'hFFFF_FFFF, 1'b1);
      send(0, 1'b0, 32'h20, 3'b010, 32'h0, 1'b1);
      v[0] = 1'b0;
   endtask

   task automatic directed1();
      for (int k = 0; k < 8; k++) begin
         send(1, 1'b1, 32'(4 * k + 64), 3'b010, $urandom, 1'b1);
         send(1, 1'b0, 32'(4 * k + 64), 3'b010, 32'h0, 1'b1);
      end
      v[1] = 1'b0;
   endtask

   task automatic directed2();
      logic [31:0] b;
      b = BASE_TAB[2];
      send(2, 1'b1, b + 32'h30, 3'b010, 32'hCAFE_F00D, 1'b1);
      send(2, 1'b0, b + 32'h30, 3'b010, 32'h0, 1'b1);
      send(2, 1'b1, b + 32'h30, 3'b010, 32'h1234_5678, 1'b0);
      @(posedge clk);
      #1;
      rst_n[2] = 1'b0;
      v[2] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n[2] = 1'b1;
      send(2, 1'b0, b + 32'h30, 3'b010, 32'h0, 1'b1);
      send(2, 1'b0, b - 32'h4, 3'b010, 32'h0, 1'b1);
      send(2, 1'b0, b + 32'h32, 3'b001, 32'h0, 1'b1);
      v[2] = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         rst_n[i] = 1'b0; v[i] = 1'b0; wr[i] = 1'b0;
         ad[i] = 32'd0; f3[i] = 3'd0; wd[i] = 32'd0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         chk(rv[i] === 1'b0, $sformatf("dut%0d reset_resp_valid", i), 32'(rv[i]), 32'd0);
         chk(rd[i] === 32'd0, $sformatf("dut%0d reset_resp_rdata", i), rd[i], 32'd0);
         chk(re[i] === 1'b0, $sformatf("dut%0d reset_resp_error", i), 32'(re[i]), 32'd0);
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) rst_n[i] = 1'b1;

      fork
         begin directed0(); rand_run(0, 150); end
         begin directed1(); rand_run(1, 150); end
         begin directed2(); rand_run(2, 150); end
      join

      for (int n = 0; n < 100; n++) begin
         if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0) break;
         @(negedge clk);
      end
      @(negedge clk);
      for (int i = 0; i < N; i++)
         chk(exp_q[i].size() == 0, $sformatf("dut%0d outstanding_responses", i),
             32'(exp_q[i].size()), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
`default_nettype wire
